cosine_sim_frontend: RTL and testbench
======================================

COSINE_SIM_FRONTEND -- requirements
Module: cosine_sim_frontend

Interface
REQ-001 SHALL have parameter W, default 5: number of 32-bit elements per vector.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256: response wait limit in cycles (used only when COSINE_SIM_TIMEOUT_EN is defined).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  input element beat valid.
REQ-007 SHALL have port s_ready  output  1  frontend accepts an input beat.
REQ-008 SHALL have port s_data  input  32  element value.
REQ-009 SHALL have port s_last  input  1  marks the final beat of a frame.
REQ-010 SHALL have port cs_start  output  1  one-cycle start pulse to the similarity engine.
REQ-011 SHALL have port cs_vec_a  output  32 x W  registered vector A.
REQ-012 SHALL have port cs_vec_b  output  32 x W  registered vector B.
REQ-013 SHALL have port cs_similarity  input  32  engine result.
REQ-014 SHALL have port cs_valid  input  1  engine result valid.
REQ-015 SHALL have port m_valid  output  1  result available.
REQ-016 SHALL have port m_ready  input  1  consumer accepts the result.
REQ-017 SHALL have port m_data  output  32  result value.
REQ-018 SHALL have port err  output  1  one-cycle framing or timeout error pulse.

Function
REQ-019 SHALL implement states LOAD, FIRE, WAIT and RESP.
REQ-020 SHALL drive s_ready=1 only in LOAD, cs_start=1 only in FIRE, and m_valid=1 only in RESP, each decoded from the state register.
REQ-021 SHALL treat a beat as accepted when s_valid and s_ready are both 1 in the same cycle.
REQ-022 SHALL make a frame exactly 2W accepted beats, counted by a beat counter idx running 0..2W-1.
REQ-023 SHALL write beat idx<W to cs_vec_a[idx] and beat idx>=W to cs_vec_b[idx-W].
REQ-024 SHALL, when beat 2W-1 is accepted with s_last=1, move to FIRE on the next cycle and reset idx to 0.
REQ-025 SHALL, when s_last=1 is accepted on any beat idx<2W-1, pulse err for one cycle, reset idx to 0, stay in LOAD and not issue cs_start.
REQ-026 SHALL, when beat 2W-1 is accepted with s_last=0, pulse err for one cycle, reset idx to 0, stay in LOAD and not issue cs_start.
REQ-027 SHALL go from FIRE to WAIT unconditionally, so cs_start is high for exactly one cycle.
REQ-028 SHALL ignore cs_valid in LOAD, FIRE and RESP.
REQ-029 SHALL, when cs_valid=1 in WAIT, register cs_similarity into m_data and go to RESP on the next cycle.
REQ-030 SHALL hold m_data and m_valid stable in RESP until m_ready=1.
REQ-031 SHALL go from RESP to LOAD on the cycle after m_valid and m_ready are both 1.
REQ-032 SHALL, from acceptance of the last beat, raise cs_start 1 cycle later and raise m_valid 1 cycle after cs_valid is sampled in WAIT.
REQ-033 SHALL hold cs_vec_a and cs_vec_b unchanged outside LOAD.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set state=LOAD, idx=0, all cs_vec_a/cs_vec_b elements=0, m_data=0 and err=0.
REQ-035 SHALL therefore give cs_start=0, m_valid=0 and s_ready=1 after reset.
REQ-036 SHALL let reset asserted in any state, including WAIT or RESP, abandon the frame and any pending result.

Configuration
REQ-037 SHALL, when COSINE_SIM_TIMEOUT_EN is defined, count cycles spent in WAIT.
REQ-038 SHALL, when that count reaches TIMEOUT_CYC with no cs_valid, load m_data=32'hFFFF_FFFF, pulse err for one cycle and go to RESP.
REQ-039 SHALL, when COSINE_SIM_TIMEOUT_EN is not defined, include no counter and wait in WAIT indefinitely; TIMEOUT_CYC is then unused.

Verification
REQ-040 SHALL cover a nominal frame: W=5, beats A=1,2,3,4,5 then B=1,2,3,4,5 with s_last on beat 9 -> cs_vec_a=cs_vec_b={1..5}, one cs_start pulse 1 cycle after beat 9; mock engine returns 32'h3F80_0000 after 20 cycles -> m_valid with m_data=32'h3F80_0000 1 cycle later.
REQ-041 SHALL cover backpressure: m_ready held 0 for 10 cycles in RESP -> m_data and m_valid stable, s_ready=0; m_ready=1 -> LOAD next cycle with s_ready=1.
REQ-042 SHALL cover early s_last: s_last on beat 3 -> err pulse, no cs_start, idx=0; a following correct 10-beat frame completes normally.
REQ-043 SHALL cover missing s_last: 10 beats with s_last=0 -> err pulse on beat 9 acceptance, no cs_start.
REQ-044 SHALL cover reset mid-operation: rst=1 for 1 cycle while in WAIT -> next cycle LOAD, m_valid=0, vectors=0; a later cs_valid is ignored.
REQ-045 SHALL cover the timeout build: with COSINE_SIM_TIMEOUT_EN defined and TIMEOUT_CYC=16, no cs_valid -> after 16 WAIT cycles err pulses and m_data=32'hFFFF_FFFF with m_valid=1.

Source files
------------

// File: rtl/cosine_sim_frontend.sv
// Cosine-similarity frontend: collects a 2W-beat frame into vectors A and B,
// fires a one-cycle start to the similarity engine, waits for its result and
// hands the result to the consumer over a valid/ready handshake.
// Optional build macro: COSINE_SIM_TIMEOUT_EN adds a WAIT-state timeout of
// TIMEOUT_CYC cycles that returns 32'hFFFF_FFFF and pulses err.
module cosine_sim_frontend #(
    parameter int unsigned W           = 5,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [31:0]         s_data,
    input  logic                s_last,
    output logic                cs_start,
    output logic [W-1:0][31:0]  cs_vec_a,
    output logic [W-1:0][31:0]  cs_vec_b,
    input  logic [31:0]         cs_similarity,
    input  logic                cs_valid,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [31:0]         m_data,
    output logic                err
);

    localparam int unsigned Beats = 2 * W;
    localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Beats - 1);

    typedef enum logic [1:0] {StLoad, StFire, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [W-1:0][31:0] vec_a_q, vec_a_d;
    logic [W-1:0][31:0] vec_b_q, vec_b_d;
    logic [31:0]        m_data_q, m_data_d;
    logic               err_q, err_d;

`ifdef COSINE_SIM_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    // Next-state logic: beat capture, framing checks, engine handshake.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_a_d  = vec_a_q;
        vec_b_d  = vec_b_q;
        m_data_d = m_data_q;
        err_d    = 1'b0;
`ifdef COSINE_SIM_TIMEOUT_EN
        tmo_d    = '0;
`endif
        unique case (state_q)
            StLoad: begin
                if (s_valid) begin
                    // Compare-per-slot avoids indexing a W-deep array with a 2W-range index.
                    for (int i = 0; i < int'(W); i++) begin
                        if (idx_q == IdxW'(i))     vec_a_d[i] = s_data;
                        if (idx_q == IdxW'(i + W)) vec_b_d[i] = s_data;
                    end
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (s_last) state_d = StFire;
                        else        err_d   = 1'b1;
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StFire: state_d = StWait;
            StWait: begin
                if (cs_valid) begin
                    m_data_d = cs_similarity;
                    state_d  = StResp;
                end
`ifdef COSINE_SIM_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    m_data_d = 32'hFFFF_FFFF;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (m_ready) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            vec_a_q  <= '0;
            vec_b_q  <= '0;
            m_data_q <= '0;
            err_q    <= 1'b0;
`ifdef COSINE_SIM_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_a_q  <= vec_a_d;
            vec_b_q  <= vec_b_d;
            m_data_q <= m_data_d;
            err_q    <= err_d;
`ifdef COSINE_SIM_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        s_ready  = (state_q == StLoad);
        cs_start = (state_q == StFire);
        m_valid  = (state_q == StResp);
        cs_vec_a = vec_a_q;
        cs_vec_b = vec_b_q;
        m_data   = m_data_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_cosine_sim_frontend.sv
// Self-checking bench for cosine_sim_frontend: table of nominal frames plus
// directed sequences for framing errors, mid-WAIT reset and (if built) timeout.
module tb_cosine_sim_frontend;

    localparam int unsigned W   = 5;
    localparam int unsigned TMO = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid, s_last, s_ready;
    logic [31:0]        s_data;
    logic               cs_start, cs_valid;
    logic [W-1:0][31:0] cs_vec_a, cs_vec_b;
    logic [31:0]        cs_similarity;
    logic               m_valid, m_ready;
    logic [31:0]        m_data;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    cosine_sim_frontend #(
        .W           (W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .cs_start      (cs_start),
        .cs_vec_a      (cs_vec_a),
        .cs_vec_b      (cs_vec_b),
        .cs_similarity (cs_similarity),
        .cs_valid      (cs_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cs_start === 1'b1) start_cnt <= start_cnt + 1;

    typedef struct {
        logic [W-1:0][31:0] a;
        logic [W-1:0][31:0] b;
        logic [31:0]        res;
        int                 delay;
        int                 hold;
    } frame_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive 2W beats back to back; last beat carries s_last only if good_last.
    task automatic send_frame(input logic [W-1:0][31:0] a, input logic [W-1:0][31:0] b,
                              input bit good_last);
        for (int i = 0; i < 2 * int'(W); i++) begin
            s_valid = 1'b1;
            s_data  = (i < int'(W)) ? a[i] : b[i - int'(W)];
            s_last  = good_last && (i == 2 * int'(W) - 1);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input int n);
        int s0;
        logic [31:0] held;
        s0 = start_cnt;
        send_frame(f.a, f.b, 1'b1);
        chk($sformatf("f%0d_cs_start_after_last", n), {31'd0, cs_start}, 32'd1);
        chk($sformatf("f%0d_no_err", n), {31'd0, err}, 32'd0);
        chk($sformatf("f%0d_s_ready_low", n), {31'd0, s_ready}, 32'd0);
        step();
        chk($sformatf("f%0d_cs_start_one_cycle", n), {31'd0, cs_start}, 32'd0);
        chk($sformatf("f%0d_one_start", n), start_cnt, s0 + 1);
        for (int i = 0; i < int'(W); i++) begin
            chk($sformatf("f%0d_vec_a%0d", n, i), cs_vec_a[i], f.a[i]);
            chk($sformatf("f%0d_vec_b%0d", n, i), cs_vec_b[i], f.b[i]);
        end
        for (int c = 0; c < f.delay; c++) step();
        chk($sformatf("f%0d_no_m_valid_in_wait", n), {31'd0, m_valid}, 32'd0);
        cs_similarity = f.res;
        cs_valid = 1'b1;
        step();
        cs_valid = 1'b0;
        cs_similarity = 32'hDEAD_BEEF;
        chk($sformatf("f%0d_m_valid", n), {31'd0, m_valid}, 32'd1);
        chk($sformatf("f%0d_m_data", n), m_data, f.res);
        held = m_data;
        for (int c = 0; c < f.hold; c++) begin
            step();
            chk($sformatf("f%0d_bp_m_valid_c%0d", n, c), {31'd0, m_valid}, 32'd1);
            chk($sformatf("f%0d_bp_m_data_c%0d", n, c), m_data, f.res);
            chk($sformatf("f%0d_bp_s_ready_c%0d", n, c), {31'd0, s_ready}, 32'd0);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk($sformatf("f%0d_back_to_load", n), {31'd0, s_ready}, 32'd1);
        chk($sformatf("f%0d_m_valid_drop", n), {31'd0, m_valid}, 32'd0);
    endtask

    frame_t vecs [3];
    logic [W-1:0][31:0] seq_a, seq_b;

    initial begin
        int s0;
        vecs[0].a = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].b = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].res = 32'h3F80_0000; vecs[0].delay = 20; vecs[0].hold = 0;
        vecs[1].a = {32'hA5A5_0005, 32'h0000_0004, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[1].b = {32'h0BAD_F00D, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hCAFE_0001};
        vecs[1].res = 32'hBF00_0000; vecs[1].delay = 0; vecs[1].hold = 10;
        vecs[2].a = {32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
        vecs[2].b = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5};
        vecs[2].res = 32'h0000_0000; vecs[2].delay = 3; vecs[2].hold = 2;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        cs_valid = 1'b0; cs_similarity = '0; m_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_cs_start", {31'd0, cs_start}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_vec_a0", cs_vec_a[0], 32'd0);
        chk("rst_vec_b4", cs_vec_b[W-1], 32'd0);

        for (int n = 0; n < 3; n++) run_frame(vecs[n], n);

        // Early s_last on beat 3.
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'(100 + i); s_last = (i == 3);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("early_err_pulse", {31'd0, err}, 32'd1);
        chk("early_s_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk("early_err_one_cycle", {31'd0, err}, 32'd0);
        chk("early_no_start", start_cnt, s0);
        run_frame(vecs[2], 3);

        // Missing s_last on beat 9.
        s0 = start_cnt;
        seq_a = {32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
        seq_b = {32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
        send_frame(seq_a, seq_b, 1'b0);
        chk("miss_err_pulse", {31'd0, err}, 32'd1);
        chk("miss_s_ready", {31'd0, s_ready}, 32'd1);
        step(); step();
        chk("miss_err_one_cycle", {31'd0, err}, 32'd0);
        chk("miss_no_start", start_cnt, s0);
        run_frame(vecs[0], 4);

        // Reset while waiting for the engine.
        send_frame(vecs[1].a, vecs[1].b, 1'b1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rstw_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rstw_vec_a0", cs_vec_a[0], 32'd0);
        chk("rstw_vec_b0", cs_vec_b[0], 32'd0);
        cs_similarity = 32'h1111_2222; cs_valid = 1'b1;
        step();
        cs_valid = 1'b0;
        step();
        chk("rstw_cs_valid_ignored_mv", {31'd0, m_valid}, 32'd0);
        chk("rstw_cs_valid_ignored_md", m_data, 32'd0);
        chk("rstw_still_load", {31'd0, s_ready}, 32'd1);

`ifdef COSINE_SIM_TIMEOUT_EN
        send_frame(vecs[0].a, vecs[0].b, 1'b1);
        step();
        for (int c = 0; c < int'(TMO) - 1; c++) step();
        chk("tmo_not_yet", {31'd0, m_valid}, 32'd0);
        step();
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_m_valid", {31'd0, m_valid}, 32'd1);
        chk("tmo_m_data", m_data, 32'hFFFF_FFFF);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("tmo_back_to_load", {31'd0, s_ready}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
